// File: rtl/stdlib_rr_grant_oh.sv
// rtl/stdlib_rr_grant_oh.sv - round-robin arbiter with registered one-hot grant and valid/ready handshake
module stdlib_rr_grant_oh #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] io_req,
    input  logic         io_out_ready,
    output logic         io_out_valid,
    output logic [N-1:0] io_grant_oh
);

    // Two-bit encoding so that a corrupted state has somewhere defined to go.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01
    } state_e;

    state_e        state_q;
    logic [PW-1:0] ptr_q;
    logic [N-1:0]  grant_q;
    logic          valid_q;

    logic [PW-1:0] win_idx;
    logic [PW-1:0] ptr_d;
    logic [N-1:0]  others;
    logic [N-1:0]  pick_idle;
    logic [N-1:0]  pick_fire;

    // First set bit of req scanning p, p+1, ... N-1, 0, ... p-1; zero if req is empty.
    function automatic logic [N-1:0] pick(input logic [N-1:0] req, input logic [PW-1:0] p);
        logic [N-1:0] res;
        logic         found;
        int           idx;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(p) + i) % N;
            if (!found && req[idx]) begin
                res[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return res;
    endfunction

    // Index of the single set bit; the grant register is one-hot by construction.
    function automatic logic [PW-1:0] oh_to_idx(input logic [N-1:0] oh);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) begin
                idx = idx | PW'(i);
            end
        end
        return idx;
    endfunction

    // Successor index with explicit wrap so non-power-of-two N never reaches N.
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        if (int'(i) >= N - 1) begin
            return '0;
        end
        return i + PW'(1);
    endfunction

    // Candidate grants for the IDLE start and for back-to-back service after a fire.
    always_comb begin
        win_idx   = oh_to_idx(grant_q);
        ptr_d     = next_idx(win_idx);
        others    = io_req & ~grant_q;
        pick_idle = pick(io_req, ptr_q);
        pick_fire = pick(others, ptr_d);
    end

    // Arbitration FSM: grant is captured on entry to HOLD and only changes on fire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|io_req) begin
                        grant_q <= pick_idle;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        grant_q <= '0;
                        valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (io_out_ready) begin
                        ptr_q <= ptr_d;
                        if (|others) begin
                            grant_q <= pick_fire;
                        end else if (!(|(io_req & grant_q))) begin
                            grant_q <= '0;
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    grant_q <= '0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign io_out_valid = valid_q;
    assign io_grant_oh  = grant_q;

endmodule

// File: doc/stdlib_rr_grant_oh.md
# stdlib_rr_grant_oh

Round-robin arbiter that turns a vector of level-sensitive requests into a registered, strictly one-hot grant with a valid/ready handshake. It is the stage directly upstream of the one-hot-to-index encoder. Its `io_grant_oh` feeds that encoder unchanged, so `io_grant_oh` must never carry more than one set bit. The grant is held stable until the consumer accepts it. The priority pointer then advances past the winner, so every persistently asserted requester is served within N grants.

## Interface
Parameters:
- `N`, default 4: number of requesters, legal range 1..16.
- `PW`, default max(1, ceil(log2 N)): width of the internal priority pointer.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset_n`  in  1: reset is asynchronous and active-low. Assertion clears all state immediately; release is synchronous to `clk`.
- `io_req`  in  N: per-requester request level. Bit i high means requester i wants service.
- `io_out_ready`  in  1: consumer accepts the current grant this cycle.
- `io_out_valid`  out  1: a grant is presented.
- `io_grant_oh`  out  N: registered grant. Exactly one bit is set when `io_out_valid`=1; all zeros otherwise.

## Operation
- Internal state:
  - `state`: IDLE or HOLD.
  - `ptr`: PW bits, the highest-priority index.
  - `grant`: N bits, one-hot.
- `io_out_valid` = (state==HOLD). `io_grant_oh` = `grant`, driven directly from flops with no combinational path from inputs.
- Selection function `pick(req, p)`: the first set bit of `req` found scanning indices p, p+1, … N-1, 0, … p-1. The result is one-hot, or zero if `req`==0.
- IDLE:
  - If `io_req`!=0: `grant` <= pick(`io_req`, `ptr`), state <= HOLD.
  - Otherwise remain IDLE, with `grant`=0.
- HOLD, no fire (`io_out_ready`=0):
  - `grant`, `ptr` and `state` are unchanged.
  - The grant is sticky. Deasserting the granted `io_req` bit does not revoke it.
  - New requests are ignored until fire.
- HOLD, fire (`io_out_ready`=1). Let g be the index of `grant`.
  - `ptr` <= (g+1) mod N.
  - If `io_req` masked with ~`grant` is nonzero: `grant` <= pick(that mask, (g+1) mod N), stay in HOLD. This is back-to-back service.
  - Otherwise, if only the current winner is still requesting: `grant` <= `grant`, stay in HOLD. The winner is re-served because it is the sole requester.
  - Otherwise (`io_req`==0): `grant` <= 0, state <= IDLE.
- N=1: `ptr` is a constant 0 and `grant` is bit 0 whenever the state is HOLD.
- `ptr` wraps from N-1 to 0. For non-power-of-two N it never takes a value ≥ N.
- Any illegal `state` encoding recovers to IDLE with `grant`=0 on the next edge.

## Timing
- Reset values: `io_out_valid`=0, `io_grant_oh`=0, `ptr`=0, state=IDLE. Outputs go low asynchronously on `reset_n` falling, with no clock needed.
- Reset asserted mid-HOLD drops the grant immediately. No fire is reported for the dropped grant.
- Latency: `io_req` rising in IDLE leads to `io_out_valid`=1 at the next edge (1 cycle).
- Throughput: one grant per cycle while `io_out_ready`=1 and requests persist. There is no bubble between grants.
- Handshake rule: while `io_out_valid`=1 and `io_out_ready`=0, `io_grant_oh` is bit-stable every cycle.
- `io_out_ready` is ignored in IDLE.
- Simultaneous events:
  - A fire and a new request in the same cycle: the new request is eligible for the next grant.
  - `io_req`=0 at fire: the block returns to IDLE, even if a request appears on the following cycle (that request is served 1 cycle later).

## Test plan
- Reset:
  - Drive `io_req`=4'b1111 during `reset_n`=0 → outputs stay 0.
  - Release reset, hold `io_out_ready`=1 → `io_grant_oh` sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, starting 1 cycle after release.
- Backpressure:
  - `io_req`=4'b0110, `io_out_ready`=0 for 5 cycles → `io_grant_oh`=0010 stable for all 5.
  - Then `io_out_ready`=1 → next grant is 0100.
- Sticky grant and wrap:
  - From `ptr`=3 (after serving index 2), `io_req`=4'b0001 → grant 0001.
  - Drop `io_req` to 0 while stalled → grant stays 0001 until fire, then IDLE with `io_out_valid`=0.
- Sole requester:
  - `io_req`=4'b1000 held, `io_out_ready`=1 → `io_grant_oh`=1000 every cycle, with no bubbles.
- Async reset mid-HOLD:
  - Assert `reset_n`=0 between clock edges while the grant is 0100 → `io_out_valid` and `io_grant_oh` go to 0 before the next edge.
  - After release, `io_req`=4'b1111 → first grant is 0001.
- One-hot invariant:
  - Random `io_req` and `io_out_ready` for 10k cycles with N=3 and N=4 → `io_grant_oh` is never multi-hot.
  - No requester that stays asserted waits more than N grants.
